// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks in-flight destination tags, resolves EX forwarding selects and load-use stalls
module fwd_scoreboard #(
    parameter int NUM_SRC  = 2,
    parameter int RADDR_W  = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_POS = 2,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [NUM_SRC*RADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [RADDR_W-1:0]         id_dst_addr,
    input  logic                       id_reg_write,
    input  logic                       id_is_load,
    input  logic                       flush,
    output logic                       stall,
    output logic                       ex_valid,
    output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel,
    output logic [CNT_W-1:0]           stall_cnt
);
    logic [DEPTH-1:0]              valid_q, valid_d, wr_q, wr_d, load_q, load_d;
    logic [DEPTH-1:0][RADDR_W-1:0] dst_q, dst_d;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel_q, fwd_sel_d, sel_next;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          hazard, issue;

    // Find the youngest producer per source, then either forward from it or flag a load-use hazard
    always_comb begin
        logic [RADDR_W-1:0] src;
        int                 pos;
        logic               ld;
        hazard   = 1'b0;
        sel_next = '0;
        src      = '0;
        pos      = 0;
        ld       = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src = id_src_addr[i*RADDR_W +: RADDR_W];
            pos = 0;
            ld  = 1'b0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (valid_q[k] && wr_q[k] && dst_q[k] == src && src != '0) begin
                    pos = k + 1;
                    ld  = load_q[k];
                end
            end
            if (id_src_used[i] && pos != 0) begin
                if (ld && pos < LOAD_POS)
                    hazard = 1'b1;
                else if (pos < DEPTH)
                    sel_next[i*SEL_W +: SEL_W] = SEL_W'(pos);
            end
        end
        stall     = id_valid && !flush && hazard;
        issue     = id_valid && !flush && !hazard;
        valid_d   = {valid_q[DEPTH-2:0], issue};
        wr_d      = {wr_q[DEPTH-2:0], id_reg_write};
        load_d    = {load_q[DEPTH-2:0], id_is_load};
        dst_d     = {dst_q[DEPTH-2:0], id_dst_addr};
        fwd_sel_d = issue ? sel_next : '0;
        cnt_d     = (stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Shift the tag pipeline every cycle; reset drops every in-flight tag immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            wr_q      <= '0;
            load_q    <= '0;
            dst_q     <= '0;
            fwd_sel_q <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            wr_q      <= wr_d;
            load_q    <= load_d;
            dst_q     <= dst_d;
            fwd_sel_q <= fwd_sel_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_valid   = valid_q[0];
    assign ex_fwd_sel = fwd_sel_q;
    assign stall_cnt  = cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed and random checks of two scoreboard configurations against an issue-history model
module tb_fwd_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [14:0] id_src_addr = '0;
    logic [2:0]  id_src_used = '0;
    logic [4:0]  id_dst_addr = '0;
    logic        id_reg_write = 1'b0;
    logic        id_is_load = 1'b0;
    logic        flush = 1'b0;

    logic        stall0, stall1, ex_valid0, ex_valid1;
    logic [3:0]  ex_sel0;
    logic [5:0]  ex_sel1;
    logic [15:0] stall_cnt0;
    logic [3:0]  stall_cnt1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fwd_scoreboard u0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr[9:0]),
        .id_src_used(id_src_used[1:0]), .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .flush(flush), .stall(stall0), .ex_valid(ex_valid0),
        .ex_fwd_sel(ex_sel0), .stall_cnt(stall_cnt0)
    );

    fwd_scoreboard #(.NUM_SRC(3), .DEPTH(4), .LOAD_POS(2), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .flush(flush), .stall(stall1), .ex_valid(ex_valid1),
        .ex_fwd_sel(ex_sel1), .stall_cnt(stall_cnt1)
    );

    // Model: list of every instruction that entered EX, stamped with the ID cycle it left
    typedef struct {
        int       m;
        int       cyc;
        logic [4:0] dst;
        bit       wr;
        bit       ld;
    } ent_t;

    ent_t       hist[$];
    int         cyc = 0;
    bit         exv[2];
    logic [5:0] esel[2];
    int         ecnt[2];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // A producer that left ID d cycles ago is at forwarding distance d; youngest (smallest d) wins
    function automatic void eval(input int m, output bit hz, output logic [5:0] sel);
        int depth, nsrc, best, p;
        bit bl;
        logic [4:0] a;
        depth = m ? 4 : 3;
        nsrc  = m ? 3 : 2;
        hz    = 1'b0;
        sel   = '0;
        for (int s = 0; s < nsrc; s++) begin
            a    = id_src_addr[s*5 +: 5];
            best = -1;
            bl   = 1'b0;
            if (id_src_used[s] && a != 5'd0) begin
                foreach (hist[j])
                    if (hist[j].m == m && hist[j].wr && hist[j].dst == a &&
                        cyc - hist[j].cyc <= depth && hist[j].cyc > best) begin
                        best = hist[j].cyc;
                        bl   = hist[j].ld;
                    end
                if (best >= 0) begin
                    p = cyc - best;
                    if (bl && p < 2) hz = 1'b1;
                    else if (p < depth) sel[s*2 +: 2] = 2'(p);
                end
            end
        end
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int m = 0; m < 2; m++) begin
            exv[m] = 1'b0;
            esel[m] = '0;
            ecnt[m] = 0;
        end
    endtask

    task automatic step(input bit v, input logic [4:0] a0, a1, a2, input logic [2:0] u,
                        input logic [4:0] d, input bit w, input bit ld, input bit fl);
        bit hz, es;
        bit iss[2];
        logic [5:0] sel;
        logic [5:0] nsel[2];
        int ncnt[2];
        ent_t e;
        id_valid = v;
        id_src_addr = {a2, a1, a0};
        id_src_used = u;
        id_dst_addr = d;
        id_reg_write = w;
        id_is_load = ld;
        flush = fl;
        #1;
        for (int m = 0; m < 2; m++) begin
            eval(m, hz, sel);
            es = v && !fl && hz;
            check(m ? "ex_valid1" : "ex_valid0", m ? 16'(ex_valid1) : 16'(ex_valid0), 16'(exv[m]));
            check(m ? "ex_sel1" : "ex_sel0", m ? 16'(ex_sel1) : 16'(ex_sel0), 16'(esel[m]));
            check(m ? "cnt1" : "cnt0", m ? 16'(stall_cnt1) : stall_cnt0, 16'(ecnt[m]));
            check(m ? "stall1" : "stall0", m ? 16'(stall1) : 16'(stall0), 16'(es));
            iss[m]  = v && !fl && !hz;
            nsel[m] = iss[m] ? sel : 6'd0;
            ncnt[m] = (es && ecnt[m] < (m ? 15 : 65535)) ? ecnt[m] + 1 : ecnt[m];
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (iss[m]) begin
                e.m = m; e.cyc = cyc; e.dst = d; e.wr = w; e.ld = ld;
                hist.push_back(e);
            end
            exv[m]  = iss[m];
            esel[m] = nsel[m];
            ecnt[m] = ncnt[m];
        end
        cyc++;
        while (hist.size() > 0 && hist[0].cyc < cyc - 6) void'(hist.pop_front());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst stall", 16'(stall0), 16'd0);
        check("rst ex_valid", 16'(ex_valid0), 16'd0);
        check("rst sel", 16'(ex_sel0), 16'd0);
        check("rst cnt", stall_cnt0, 16'd0);
        rst_n = 1'b1;
        idle(1);

        // back-to-back ALU forward
        step(1, 0, 0, 0, 3'b000, 3, 1, 0, 0);
        step(1, 3, 0, 0, 3'b001, 1, 1, 0, 0);
        check("t1 sel", 16'(ex_sel0[1:0]), 16'd1);
        check("t1 valid", 16'(ex_valid0), 16'd1);
        idle(4);

        // distance-2 forward on src1
        step(1, 0, 0, 0, 3'b000, 5, 1, 0, 0);
        step(1, 0, 0, 0, 3'b000, 6, 1, 0, 0);
        step(1, 0, 5, 0, 3'b010, 1, 1, 0, 0);
        check("t2 sel0", 16'(ex_sel0[3:2]), 16'd2);
        check("t2 sel1", 16'(ex_sel1[3:2]), 16'd2);
        idle(4);

        // load-use: one bubble then forward from position 2
        step(1, 0, 0, 0, 3'b000, 4, 1, 1, 0);
        step(1, 4, 0, 0, 3'b001, 8, 1, 0, 0);
        check("t3 bubble", 16'(ex_valid0), 16'd0);
        check("t3 cnt", stall_cnt0, 16'd1);
        step(1, 4, 0, 0, 3'b001, 8, 1, 0, 0);
        check("t3 sel", 16'(ex_sel0[1:0]), 16'd2);
        check("t3 valid", 16'(ex_valid0), 16'd1);
        idle(4);

        // youngest producer wins; r0 never forwards or stalls
        step(1, 0, 0, 0, 3'b000, 7, 1, 0, 0);
        step(1, 0, 0, 0, 3'b000, 7, 1, 0, 0);
        step(1, 7, 0, 0, 3'b001, 9, 1, 0, 0);
        check("t4 young", 16'(ex_sel0[1:0]), 16'd1);
        step(1, 0, 0, 0, 3'b000, 0, 1, 1, 0);
        step(1, 0, 0, 0, 3'b001, 10, 1, 0, 0);
        check("t4 r0 sel", 16'(ex_sel0[1:0]), 16'd0);
        check("t4 r0 valid", 16'(ex_valid0), 16'd1);
        idle(4);

        // flush beats load-use stall
        step(1, 0, 0, 0, 3'b000, 4, 1, 1, 0);
        step(1, 4, 0, 0, 3'b001, 8, 1, 0, 1);
        check("t5 bubble", 16'(ex_valid0), 16'd0);
        check("t5 cnt", stall_cnt0, 16'd1);
        idle(4);

        // producer three ahead: retired for DEPTH=3, still forwardable for DEPTH=4
        step(1, 0, 0, 0, 3'b000, 2, 1, 0, 0);
        step(1, 0, 0, 0, 3'b000, 11, 1, 0, 0);
        step(1, 0, 0, 0, 3'b000, 12, 1, 0, 0);
        step(1, 2, 0, 0, 3'b001, 13, 1, 0, 0);
        check("t6 d3 sel", 16'(ex_sel0[1:0]), 16'd0);
        check("t6 d4 sel", 16'(ex_sel1[1:0]), 16'd3);
        idle(4);

        // asynchronous reset in the middle of a load-use stall
        step(1, 0, 0, 0, 3'b000, 4, 1, 1, 0);
        id_valid = 1; id_src_addr = 15'd4; id_src_used = 3'b001; id_dst_addr = 5'd8;
        id_reg_write = 1; id_is_load = 0; flush = 0;
        #1;
        check("rst pre stall", 16'(stall0), 16'd1);
        rst_n = 1'b0;
        #1;
        check("rst mid stall", 16'(stall0), 16'd0);
        check("rst mid stall1", 16'(stall1), 16'd0);
        check("rst mid sel", 16'(ex_sel0), 16'd0);
        check("rst mid valid", 16'(ex_valid0), 16'd0);
        check("rst mid cnt", stall_cnt0, 16'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 4, 0, 0, 3'b001, 8, 1, 0, 0);
        check("rst no stale", 16'(ex_sel0), 16'd0);

        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) < 85,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
